ripple_count_sampler: RTL and testbench
=======================================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit asynchronous ripple up-counter.
- Brings the ripple count into the synchronous `clk` domain. Every bit toggles from a different flop, so raw samples taken mid-ripple are meaningless. The block filters out those transient values and publishes only settled counts.
- Detects counter wrap-around and extends the count with a wrap counter.
- Hands a coherent {wraps, count} snapshot to the consumer over a 4-phase req/ack handshake.

Parameters:
- W, 4: width of the ripple count input.
- EW, 4: width of the wrap (extension) counter.
- STABLE_N, 2: consecutive unchanged synchronized samples needed before a value is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- count  input  W  raw ripple-counter value, asynchronous to clk.
- clr  input  1  synchronous clear of wraps and ovf.
- snap_req  input  1  snapshot request, level, 4-phase.
- cnt_out  output  W  last accepted (settled) count.
- upd  output  1  one-cycle pulse when cnt_out changes.
- wrap  output  1  one-cycle pulse when an accepted value is numerically lower than the previous one.
- wraps  output  EW  wrap counter, modulo 2^EW.
- ovf  output  1  sticky; set when wraps rolls from all-ones to 0.
- snap_ack  output  1  snapshot acknowledge.
- snap_data  output  EW+W  captured value {wraps, cnt_out}.
- skip_err  output  1  sticky step-error flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared. Outputs cnt_out=0, upd=0, wrap=0, wraps=0, ovf=0, snap_ack=0, snap_data=0, skip_err=0. Filter state is UNSTABLE; handshake state is S_IDLE.
- Reset is recognised mid-operation: an asserted snap_ack or a pending accept is abandoned immediately. After rst deasserts, the first acceptance compares against cnt_out=0.
- Synchronizer: two flops per bit, s1 then s2. No bit is used before s2.
- Filter FSM, counter stab (4 bits, saturating at STABLE_N-1):
  - On any edge where s2 changes: stab=0, state UNSTABLE.
  - On an edge where s2 is unchanged and stab==STABLE_N-1: accept. If s2 != cnt_out, load cnt_out=s2 and pulse upd. State becomes STABLE.
  - Otherwise, with s2 unchanged: stab increments.
  - While STABLE with s2 unchanged: no further accept or pulse.
- Latency, clean input change to cnt_out/upd: 2+STABLE_N clk edges (4 edges at defaults). upd and wrap are high during the cycle following the accepting edge.
- Wrap detection, evaluated only at an accepting edge:
  - new < old cnt_out: wrap pulses and wraps increments modulo 2^EW.
  - wraps going from 2^EW-1 to 0: ovf set.
  - Equal values: no upd and no wrap.
- clr=1: wraps=0 and ovf=0 next edge. If clr and a wrap event coincide, clr wins: wraps=0, and the wrap pulse still fires. clr does not affect cnt_out or skip_err.
- Handshake FSM:
  - S_IDLE: if snap_req=1, capture snap_data={wraps, cnt_out} using the register values before this edge's updates. snap_ack=1 from the next cycle; go to S_ACK.
  - S_ACK: snap_data and snap_ack hold. When snap_req=0, snap_ack=0 next cycle; return to S_IDLE.
  - A snap_req already high when rst releases is served one cycle after release.
- Wrap-around of cnt_out itself is natural modulo 2^W; no saturation.

Optional Feature:
- Macro: SAMPLER_SKIP_CHECK_EN.
- Defined: at each accepting edge where the value changes, if new != (old+1) mod 2^W, skip_err sets and stays sticky until rst. clr does not clear it. This catches missed counts when the ripple counter runs faster than the filter can follow.
- Undefined: skip_err is tied to 0 and no comparison logic is generated.

Test Plan:
- Reset release, count=0 held: after 10 cycles cnt_out=0, upd never asserted, snap_ack=0.
- count steps 0->1, clean, STABLE_N=2: cnt_out=1 and upd high exactly 4 edges after the change. One upd pulse only.
- count glitch 3->2->0->4 with 1-cycle gaps, then holds 4: cnt_out goes 3->4 directly. No wrap; intermediate values are never accepted.
- count ramps 14,15,0 with each value held 8 cycles: wrap pulses on acceptance of 0, wraps=1. After 16 such wraps with EW=4: wraps=0, ovf=1. clr coinciding with a wrap edge gives wraps=0.
- snap_req raised while cnt_out=5, wraps=2: next cycle snap_ack=1 and snap_data=0x25. A change to count 6 while acked leaves snap_data=0x25. Dropping snap_req gives snap_ack=0 next cycle.
- With SAMPLER_SKIP_CHECK_EN: accepted 2->5 sets skip_err=1; it stays set after clr. Without the macro, skip_err stays 0.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: brings an asynchronous 4-bit ripple count into the clk domain,
//   publishes only settled values, extends the count with a wrap counter and
//   serves {wraps, count} snapshots over a 4-phase req/ack handshake.
// Latency: clean input change to cnt_out/upd is 2+STABLE_N clk edges; snap_ack one cycle after snap_req.
// Backpressure: none on count (values that never settle are dropped); snapshot held while snap_req stays high.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   count           raw ripple-counter value (asynchronous to clk)
//   clr             synchronous clear of wraps and ovf
//   snap_req        4-phase snapshot request (level)
//   cnt_out, upd    last settled count, one-cycle pulse when it changes
//   wrap, wraps     wrap pulse and wrap counter (modulo 2^EW)
//   ovf             sticky wrap-counter overflow
//   snap_ack        snapshot acknowledge, snap_data = captured {wraps, cnt_out}
//   skip_err        sticky step-error flag; only live when SAMPLER_SKIP_CHECK_EN is defined
//
// Optional feature macro: SAMPLER_SKIP_CHECK_EN (flags accepted steps other than +1).

module ripple_count_sampler #(
  parameter int W        = 4,
  parameter int EW       = 4,
  parameter int STABLE_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      count,
  input  logic              clr,
  input  logic              snap_req,
  output logic [W-1:0]      cnt_out,
  output logic              upd,
  output logic              wrap,
  output logic [EW-1:0]     wraps,
  output logic              ovf,
  output logic              snap_ack,
  output logic [EW+W-1:0]   snap_data,
  output logic              skip_err
);

  localparam logic [3:0] STAB_MAX = 4'(STABLE_N - 1);

  typedef enum logic {F_UNSTABLE, F_STABLE} filt_e;
  typedef enum logic {S_IDLE, S_ACK} hs_e;

  // Synchronizer
  logic [W-1:0]    s1_q, s2_q;

  // Filter
  filt_e           filt_q;
  logic [3:0]      stab_q;
  logic [W-1:0]    cnt_q;
  logic            upd_q;
  logic            wrap_q;

  // Wrap extension
  logic [EW-1:0]   wraps_q, wraps_d;
  logic            ovf_q, ovf_d;

  // Handshake
  hs_e             hs_q;
  logic            ack_q;
  logic [EW+W-1:0] snap_q;

  logic s2_chg;
  logic accept;
  logic val_chg;
  logic is_wrap;

  // s2 is about to take s1's value, so a difference here is a change of s2 at this edge.
  assign s2_chg  = (s1_q != s2_q);
  assign accept  = !s2_chg && (filt_q == F_UNSTABLE) && (stab_q == STAB_MAX);
  assign val_chg = accept && (s2_q != cnt_q);
  assign is_wrap = val_chg && (s2_q < cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= count;
      s2_q <= s1_q;
    end
  end

  // Filter FSM: a value is taken only after it has sat unchanged in s2 long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= F_UNSTABLE;
      stab_q <= '0;
      cnt_q  <= '0;
      upd_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      upd_q  <= val_chg;
      wrap_q <= is_wrap;
      if (s2_chg) begin
        stab_q <= '0;
        filt_q <= F_UNSTABLE;
      end else if (filt_q == F_UNSTABLE) begin
        if (stab_q == STAB_MAX) begin
          filt_q <= F_STABLE;
          if (val_chg) begin
            cnt_q <= s2_q;
          end
        end else begin
          stab_q <= stab_q + 4'd1;
        end
      end
    end
  end

  // clr takes priority over a coincident wrap; the wrap pulse itself is unaffected.
  always_comb begin
    wraps_d = wraps_q;
    ovf_d   = ovf_q;
    if (is_wrap) begin
      wraps_d = wraps_q + EW'(1);
      if (wraps_q == '1) begin
        ovf_d = 1'b1;
      end
    end
    if (clr) begin
      wraps_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wraps_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wraps_q <= wraps_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake FSM: snapshot uses register values from before this edge's updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q   <= S_IDLE;
      ack_q  <= 1'b0;
      snap_q <= '0;
    end else if (hs_q == S_IDLE) begin
      if (snap_req) begin
        snap_q <= {wraps_q, cnt_q};
        ack_q  <= 1'b1;
        hs_q   <= S_ACK;
      end
    end else begin
      if (!snap_req) begin
        ack_q <= 1'b0;
        hs_q  <= S_IDLE;
      end
    end
  end

`ifdef SAMPLER_SKIP_CHECK_EN
  logic [W-1:0] cnt_inc;
  logic         skip_q;

  assign cnt_inc = cnt_q + W'(1);

  // Any accepted change other than +1 means the counter outran the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_q <= 1'b0;
    end else if (val_chg && (s2_q != cnt_inc)) begin
      skip_q <= 1'b1;
    end
  end

  assign skip_err = skip_q;
`else
  assign skip_err = 1'b0;
`endif

  assign cnt_out   = cnt_q;
  assign upd       = upd_q;
  assign wrap      = wrap_q;
  assign wraps     = wraps_q;
  assign ovf       = ovf_q;
  assign snap_ack  = ack_q;
  assign snap_data = snap_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: directed stimulus with an upd/snapshot scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).

module tb_ripple_count_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       clr;
  logic       snap_req;
  logic [3:0] cnt_out;
  logic       upd;
  logic       wrap;
  logic [3:0] wraps;
  logic       ovf;
  logic       snap_ack;
  logic [7:0] snap_data;
  logic       skip_err;

`ifdef SAMPLER_SKIP_CHECK_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  ripple_count_sampler #(.W(4), .EW(4), .STABLE_N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .clr       (clr),
    .snap_req  (snap_req),
    .cnt_out   (cnt_out),
    .upd       (upd),
    .wrap      (wrap),
    .wraps     (wraps),
    .ovf       (ovf),
    .snap_ack  (snap_ack),
    .snap_data (snap_data),
    .skip_err  (skip_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cnt;
    logic       wrp;
    logic [3:0] wrps;
    logic       ov;
    logic       skp;
  } upd_t;

  upd_t       upd_exp_q[$];
  logic [7:0] snap_exp_q[$];

  int checks = 0;
  int errors = 0;

  // Expected-state tracker for accepted values
  logic [3:0] m_cnt   = 4'd0;
  logic [3:0] m_wraps = 4'd0;
  logic       m_ovf   = 1'b0;
  logic       m_skip  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 4'd0;
    m_wraps = 4'd0;
    m_ovf   = 1'b0;
    m_skip  = 1'b0;
  endtask

  // Queue the upd response expected once v settles; clr_hit marks clr on the accept edge.
  task automatic expect_accept(input logic [3:0] v, input bit clr_hit);
    upd_t e;
    logic w;
    logic [3:0] inc;
    if (v != m_cnt) begin
      w = (v < m_cnt);
      if (w) begin
        if (m_wraps == 4'hf) m_ovf = 1'b1;
        m_wraps = m_wraps + 4'd1;
      end
      if (clr_hit) begin
        m_wraps = 4'd0;
        m_ovf   = 1'b0;
      end
      inc = m_cnt + 4'd1;
      if (SKIP_ON && (v != inc)) m_skip = 1'b1;
      m_cnt  = v;
      e.cnt  = v;
      e.wrp  = w;
      e.wrps = m_wraps;
      e.ov   = m_ovf;
      e.skp  = m_skip;
      upd_exp_q.push_back(e);
    end
  endtask

  task automatic hold_raw(input logic [3:0] v, input int n);
    @(posedge clk);
    #1 count = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic step(input logic [3:0] v);
    expect_accept(v, 1'b0);
    hold_raw(v, 8);
  endtask

  // Monitor: compares every upd pulse and every snap_ack rise against the queues.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    upd_t got, e;
    logic [7:0] se;
    if (upd === 1'b1) begin
      checks++;
      got = {cnt_out, wrap, wraps, ovf, skip_err};
      if (upd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: got cnt=%0h with no pending expectation at %0t", cnt_out, $time);
      end else begin
        e = upd_exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL upd_fields: got cnt=%0h wrap=%0b wraps=%0h ovf=%0b skip=%0b expected cnt=%0h wrap=%0b wraps=%0h ovf=%0b skip=%0b at %0t",
                   got.cnt, got.wrp, got.wrps, got.ov, got.skp, e.cnt, e.wrp, e.wrps, e.ov, e.skp, $time);
        end
      end
    end
    if (wrap === 1'b1) begin
      checks++;
      if (upd !== 1'b1) begin
        errors++;
        $display("FAIL wrap_without_upd: got upd=%0b expected 1 at %0t", upd, $time);
      end
    end
    if (snap_ack === 1'b1 && prev_ack === 1'b0) begin
      checks++;
      if (snap_exp_q.size() == 0) begin
        errors++;
        $display("FAIL snap_unexpected: got data=%0h with no pending request at %0t", snap_data, $time);
      end else begin
        se = snap_exp_q.pop_front();
        if (snap_data !== se) begin
          errors++;
          $display("FAIL snap_data: got %0h expected %0h at %0t", snap_data, se, $time);
        end
      end
    end
    prev_ack = snap_ack;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; count = 4'd0; clr = 1'b0; snap_req = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", {cnt_out, upd, wrap, wraps, ovf, snap_ack, snap_data, skip_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_cnt_out", cnt_out, 32'h0);
    chk("idle_snap_ack", snap_ack, 32'h0);

    // Clean 0->1 step: settled value appears exactly 4 edges after the change
    @(posedge clk);
    #1 count = 4'd1;
    expect_accept(4'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_edge3_upd", upd, 32'h0);
    chk("lat_edge3_cnt", cnt_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edge4_upd", upd, 32'h1);
    chk("lat_edge4_cnt", cnt_out, 32'h1);
    repeat (8) @(posedge clk);

    // Glitch sequence: 3 settles, then 2,0 for one cycle each, then 4
    step(4'd3);
    hold_raw(4'd2, 1);
    hold_raw(4'd0, 1);
    step(4'd4);
    @(negedge clk);
    chk("glitch_cnt", cnt_out, 32'h4);
    chk("glitch_wraps", wraps, 32'h0);

    // Ramp 14,15,0: one wrap
    step(4'd14);
    step(4'd15);
    step(4'd0);
    @(negedge clk);
    chk("first_wrap_wraps", wraps, 32'h1);

    // 15 more wraps: wrap counter rolls to 0 and ovf sets
    for (int i = 0; i < 15; i++) begin
      step(4'd15);
      step(4'd0);
    end
    @(negedge clk);
    chk("roll_wraps", wraps, 32'h0);
    chk("roll_ovf", ovf, 32'h1);

    // clr on the same edge as a wrap: clr wins, wrap still pulses
    step(4'd15);
    @(posedge clk);
    #1 count = 4'd0;
    expect_accept(4'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_wrap_pulse", wrap, 32'h1);
    chk("clr_wrap_wraps", wraps, 32'h0);
    chk("clr_wrap_ovf", ovf, 32'h0);
    repeat (6) @(posedge clk);

    // Build cnt_out=5, wraps=2 for the snapshot
    step(4'd5);
    step(4'd0);
    step(4'd5);
    step(4'd0);
    step(4'd5);
    @(negedge clk);
    chk("pre_snap_state", {wraps, cnt_out}, 32'h25);
    @(posedge clk);
    #1 snap_req = 1'b1;
    snap_exp_q.push_back(8'h25);
    @(posedge clk);
    @(negedge clk);
    chk("snap_ack_rise", snap_ack, 32'h1);
    chk("snap_data_first", snap_data, 32'h25);
    step(4'd6);
    @(negedge clk);
    chk("snap_data_hold", snap_data, 32'h25);
    chk("snap_ack_hold", snap_ack, 32'h1);
    @(posedge clk);
    #1 snap_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("snap_ack_drop", snap_ack, 32'h0);

    // Reset mid-operation: ack and pending accept abandoned; request served after release
    @(posedge clk);
    #1 snap_req = 1'b1;
    snap_exp_q.push_back(8'h26);
    @(posedge clk);
    #1 count = 4'd9;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ack", snap_ack, 32'h0);
    chk("midrst_state", {cnt_out, wraps, ovf, upd}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    snap_exp_q.push_back(8'h00);
    expect_accept(4'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1 snap_req = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt", cnt_out, 32'h9);

    // clr leaves cnt_out and skip_err alone
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_keeps_cnt", cnt_out, 32'h9);
    chk("clr_keeps_skip", skip_err, {31'h0, SKIP_ON});

    // Drain: every queued expectation must have been seen
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("upd_queue_empty", upd_exp_q.size(), 32'h0);
    chk("snap_queue_empty", snap_exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
